mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter BASE_NIBBLE, default 4'hB, Addr[31:28] value that selects this block.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (legal range 2..65535).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, 2..64).
REQ-004 The block SHALL have port clk  input  1  CPU clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port BUS  inout  32  shared data bus; driven only during a selected read, else high-Z.
REQ-007 The block SHALL have port Memread  input  1  CPU read strobe.
REQ-008 The block SHALL have port Memwrite  input  2  CPU write strobe; any nonzero value is a write.
REQ-009 The block SHALL have port Addr  input  32  CPU address.
REQ-010 The block SHALL have port tx  output  1  serial line, idle high.
REQ-011 The block SHALL have port irq  output  1  high while FIFO empty and serializer idle.

Function
REQ-012 Select SHALL be Addr[31:28]==BASE_NIBBLE; register offset is Addr[3:2]: 0 = DATA, 1 = STATUS, 2/3 = reserved.
REQ-013 A selected write to DATA with Memwrite!=0 at a clk edge SHALL push BUS[7:0] into the FIFO, one push per edge the strobe is high.
REQ-014 A selected read (Memread=1, Memwrite=0) SHALL drive BUS combinationally; STATUS = {24'b0, count[3:0], overflow, busy, empty, full}; DATA and reserved offsets read 0.
REQ-015 Push when full SHALL be discarded and set sticky overflow, unless a pop occurs on the same edge, in which case the push is accepted.
REQ-016 overflow SHALL clear on the edge ending a selected STATUS read; a simultaneous new overflow event wins (stays 1).
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP (plus PARITY per REQ-025); busy = state!=IDLE.
REQ-018 IDLE with FIFO non-empty at an edge SHALL pop the head into the shift register and enter START; tx=0 from that edge, so a write to an idle empty block at edge N gives tx low at edge N+1.
REQ-019 Each bit SHALL last exactly CLKS_PER_BIT cycles; DATA sends 8 bits LSB first; STOP drives tx=1.
REQ-020 At the end of STOP, a non-empty FIFO SHALL pop and go directly to START (no idle gap); otherwise go to IDLE; frame = 10*CLKS_PER_BIT cycles.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH; full = count==FIFO_DEPTH.
REQ-022 Writes and reads not selecting this block SHALL have no effect and leave BUS undriven.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set tx=1, state=IDLE, FIFO empty (count=0), overflow=0, bit counter/shift register=0, irq=1; rst mid-frame aborts the frame immediately with tx=1 on the next edge.
REQ-024 rst SHALL take priority over any simultaneous write or read side effect.

Configuration
REQ-025 With macro MMIO_UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state after DATA sending even parity of the 8 data bits for CLKS_PER_BIT cycles (frame = 11*CLKS_PER_BIT); without it, no parity bit is sent and the PARITY state does not exist.

Verification
REQ-026 Idle, CLKS_PER_BIT=16: write 0x0000_0055 to 0xB000_0000 -> tx low 1 edge later for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, stop high; irq=1 after 160 cycles.
REQ-027 Write 3 bytes back-to-back -> three contiguous frames, 480 cycles total, no idle cycle between stop and next start.
REQ-028 9 writes while busy with FIFO_DEPTH=8 -> STATUS reads full=1, overflow=1; second STATUS read shows overflow=0; 9th byte never transmitted.
REQ-029 Assert rst for one edge in the middle of DATA -> tx=1, STATUS=0x0000_0002, no further frame output.
REQ-030 Read 0xA000_0004 and write 0xA000_0000 -> BUS high-Z from this block, FIFO unchanged; with MMIO_UART_TX_PARITY_EN, byte 0x07 -> parity bit 1, frame 176 cycles.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter with a small transmit FIFO.
// Writes to DATA queue bytes, STATUS reports FIFO and line state, and a
// serializer sends 8N1 frames (idle-high line, LSB first).
// Optional build macro: MMIO_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [3:0] BASE_NIBBLE  = 4'hB,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  input  logic        Memread,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] Addr,
  output logic        tx,
  output logic        irq
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic [15:0]        baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_q;
`ifdef MMIO_UART_TX_PARITY_EN
  logic               parity_q;
`endif

  // Bus decode
  logic        sel, wr_data, rd_en, status_rd;
  logic [1:0]  off;
  logic        empty, full, busy, pop, push_ok, ovf_event, bit_end;
  logic [7:0]  count8;
  logic [31:0] rdata;
  logic        unused_bits;

  assign sel       = (Addr[31:28] == BASE_NIBBLE);
  assign off       = Addr[3:2];
  assign wr_data   = sel && (Memwrite != 2'b00) && (off == 2'd0);
  assign rd_en     = sel && Memread && (Memwrite == 2'b00);
  assign status_rd = rd_en && (off == 2'd1);

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign busy      = (state_q != S_IDLE);
  assign bit_end   = (baud_cnt == BIT_LAST);
  // A push into a full FIFO still lands when the serializer pops on the same edge.
  assign push_ok   = wr_data && (!full || pop);
  assign ovf_event = wr_data && full && !pop;

  assign count8 = 8'(count);
  assign rdata  = (off == 2'd1) ? {24'h0, count8[3:0], overflow, busy, empty, full} : 32'h0;
  // NOTE: the bus is released to high-Z whenever this block is not the selected reader.
  assign BUS    = rd_en ? rdata : 32'bz;

  assign irq = !busy && empty;

  assign unused_bits = ^{Addr[27:4], Addr[1:0], BUS[31:8], count8[7:4]};

  // Next-state, FIFO pop request and serial line level.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    pop     = 1'b0;
    tx      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef MMIO_UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: begin
        tx = parity_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FIFO pointers/count, overflow flag, bit timing and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);

      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A fresh overflow on the clearing read edge keeps the flag set.
      if (ovf_event)      overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;

      if (state_q == S_IDLE || bit_end) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + 16'd1;

      if (pop) begin
        shift_q <= mem[rd_ptr];
        bit_idx <= '0;
        rd_ptr  <= rd_ptr + PTR_W'(1);
`ifdef MMIO_UART_TX_PARITY_EN
        parity_q <= ^mem[rd_ptr];
`endif
      end else if (state_q == S_DATA && bit_end) begin
        shift_q <= shift_q >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; only the pointers and count define validity.
    if (push_ok && !rst) mem[wr_ptr] <= BUS[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. A frame-level reference model tracks
// queued bytes and frame start/end times; tx and irq are compared every cycle
// and bus reads are compared against the model's register view.
module tb_mmio_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam logic [31:0] DATA_ADDR   = 32'hB000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hB000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        Memread;
  logic [1:0]  Memwrite;
  logic [31:0] Addr;
  logic [31:0] bus_drv;
  logic        drive;
  tri1  [31:0] BUS;
  logic        tx;
  logic        irq;

  assign BUS = drive ? bus_drv : 32'bz;

  mmio_uart_tx #(
    .BASE_NIBBLE (4'hB),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .BUS     (BUS),
    .Memread (Memread),
    .Memwrite(Memwrite),
    .Addr    (Addr),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         e = 0;          // number of rising edges seen
  logic [7:0] q[$];           // bytes waiting in the FIFO
  int         frame_end = 0;  // edge at which the current frame finishes
  int         fstart = 0;     // edge at which the current frame began
  logic [7:0] cur = 8'h00;    // byte on the line
  logic       m_ovf = 1'b0;
  logic       m_valid = 1'b0;
  logic       exp_tx = 1'b1;
  logic       exp_irq = 1'b1;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef MMIO_UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int   cnt;
    logic line_busy;
    cnt       = q.size();
    line_busy = (e < frame_end);
    return {24'h0, 4'(cnt), m_ovf, line_busy, cnt == 0, cnt == DEPTH};
  endfunction

  task automatic model_step();
    logic sel, wr, st_rd, popped;
    e++;
    sel   = (Addr[31:28] == 4'hB);
    wr    = sel && (Memwrite != 2'b00) && (Addr[3:2] == 2'd0);
    st_rd = sel && Memread && (Memwrite == 2'b00) && (Addr[3:2] == 2'd1);
    if (rst) begin
      q.delete();
      frame_end = e;
      m_ovf     = 1'b0;
      m_valid   = 1'b1;
    end else begin
      popped = (e >= frame_end) && (q.size() > 0);
      if (popped) begin
        cur       = q.pop_front();
        fstart    = e;
        frame_end = e + FRAME;
      end
      if (wr) begin
        if (q.size() < DEPTH) q.push_back(bus_drv[7:0]);
        else                  m_ovf = 1'b1;
      end else if (st_rd) begin
        m_ovf = 1'b0;
      end
    end
    exp_tx  = (e < frame_end) ? frame_bit(cur, (e - fstart) / CPB) : 1'b1;
    exp_irq = !(e < frame_end) && (q.size() == 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Line and interrupt compared against the model every cycle.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("tx_line", {31'h0, tx}, {31'h0, exp_tx});
      check("irq", {31'h0, irq}, {31'h0, exp_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (e < target) step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    Addr     = a;
    Memwrite = 2'($urandom_range(1, 3));
    bus_drv  = {24'h0, d};
    drive    = 1'b1;
    step();
    drive    = 1'b0;
    Memwrite = 2'b00;
    Addr     = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Addr    = a;
    Memread = 1'b1;
    #1;
    d = BUS;
    step();
    Memread = 1'b0;
    Addr    = 32'h0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a);
    logic [31:0] expv, got;
    if (a[31:28] != 4'hB)    expv = 32'hFFFF_FFFF;
    else if (a[3:2] == 2'd1) expv = exp_status();
    else                     expv = 32'h0;
    bus_read(a, got);
    check(tag, got, expv);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (((e < frame_end) || (q.size() != 0)) && guard < 20000) begin
      step();
      guard++;
    end
    check(tag, {31'h0, irq}, 32'h1);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [31:0] got, r;
    logic [7:0]  b;
    int          w, n;

    rst = 1'b1; Memread = 1'b0; Memwrite = 2'b00; Addr = 32'h0;
    bus_drv = 32'h0; drive = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h1);
    bus_read(STATUS_ADDR, got);
    check("reset_status", got, 32'h0000_0002);

    // Single 0x55 frame with exact bit boundaries
    bus_write(DATA_ADDR, 8'h55);
    w = e;
    check("w55_idle_at_write", {31'h0, tx}, 32'h1);
    wait_until(w + 1);       check("w55_start_first", {31'h0, tx}, 32'h0);
    wait_until(w + CPB);     check("w55_start_last", {31'h0, tx}, 32'h0);
    wait_until(w + CPB + 1); check("w55_bit0", {31'h0, tx}, 32'h1);
    wait_until(w + 2*CPB + 1); check("w55_bit1", {31'h0, tx}, 32'h0);
    wait_until(w + FRAME);   check("w55_stop_last", {31'h0, tx}, 32'h1);
    check("w55_irq_busy", {31'h0, irq}, 32'h0);
    wait_until(w + FRAME + 1);
    check("w55_irq_done", {31'h0, irq}, 32'h1);
    read_check("w55_status_idle", STATUS_ADDR);

    // Random byte through an address with don't-care bits set
    r = $urandom;
    bus_write({4'hB, r[27:4], 2'b00, r[1:0]}, 8'($urandom));
    drain("rand_addr_drain");

    // Three back-to-back frames with no idle gap
    bus_write(DATA_ADDR, 8'($urandom));
    w = e;
    bus_write(DATA_ADDR, 8'($urandom));
    bus_write(DATA_ADDR, 8'($urandom));
    read_check("b2b_status", STATUS_ADDR);
    wait_until(w + FRAME);     check("b2b_stop1", {31'h0, tx}, 32'h1);
    wait_until(w + FRAME + 1); check("b2b_start2", {31'h0, tx}, 32'h0);
    wait_until(w + 3*FRAME);   check("b2b_busy_end", {31'h0, irq}, 32'h0);
    wait_until(w + 3*FRAME + 1); check("b2b_idle", {31'h0, irq}, 32'h1);

    // Overflow: one byte on the line, nine more into an 8-deep FIFO
    bus_write(DATA_ADDR, 8'hA0);
    for (int i = 1; i <= 9; i++) bus_write(DATA_ADDR, 8'(8'hA0 + i));
    bus_read(STATUS_ADDR, got);
    check("ovf_status1", got, 32'h0000_008D);
    read_check("ovf_status2_model", STATUS_ADDR);
    bus_read(STATUS_ADDR, got);
    check("ovf_status3", got, 32'h0000_0085);
    // Push into a full FIFO on the edge the serializer pops
    wait_until(frame_end - 1);
    bus_write(DATA_ADDR, 8'hC3);
    bus_read(STATUS_ADDR, got);
    check("full_push_pop_status", got, 32'h0000_0085);
    drain("ovf_drain");

    // Reset in the middle of DATA aborts the frame
    bus_write(DATA_ADDR, 8'($urandom));
    w = e;
    bus_write(DATA_ADDR, 8'($urandom));
    wait_until(w + 1 + 3*CPB + 5);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_tx", {31'h0, tx}, 32'h1);
    bus_read(STATUS_ADDR, got);
    check("midrst_status", got, 32'h0000_0002);
    wait_until(e + 2*FRAME);

    // Reset wins over a simultaneous write
    rst = 1'b1; Addr = DATA_ADDR; Memwrite = 2'b01; bus_drv = 32'h5A; drive = 1'b1;
    step();
    rst = 1'b0; Memwrite = 2'b00; drive = 1'b0; Addr = 32'h0;
    bus_read(STATUS_ADDR, got);
    check("rst_write_status", got, 32'h0000_0002);
    wait_until(e + 20);

    // Unselected accesses leave the bus alone and the FIFO untouched
    Addr = 32'hA000_0004; Memread = 1'b1;
    #1;
    check("unsel_read_hiz", BUS, 32'hFFFF_FFFF);
    step();
    Memread = 1'b0; Addr = 32'h0;
    bus_write(32'hA000_0000, 8'h3C);
    bus_read(STATUS_ADDR, got);
    check("unsel_write_status", got, 32'h0000_0002);
    bus_read(DATA_ADDR, got);
    check("data_reads_zero", got, 32'h0);
    bus_read(32'hB000_0008, got);
    check("reserved_reads_zero", got, 32'h0);
    wait_until(e + 30);

`ifdef MMIO_UART_TX_PARITY_EN
    bus_write(DATA_ADDR, 8'h07);
    w = e;
    wait_until(w + 1 + 9*CPB + CPB/2);
    check("par_bit", {31'h0, tx}, 32'h1);
    wait_until(w + 176);     check("par_stop_last", {31'h0, irq}, 32'h0);
    wait_until(w + 177);     check("par_idle", {31'h0, irq}, 32'h1);
`endif

    // Random traffic: bursts, gaps, stray and reserved accesses
    repeat (30) begin
      n = $urandom_range(0, 9);
      if (n < 6) begin
        repeat ($urandom_range(1, 12)) begin
          r = $urandom;
          b = 8'($urandom);
          bus_write({($urandom_range(0, 4) == 0) ? 4'hA : 4'hB, r[27:4],
                     ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0, r[1:0]}, b);
        end
      end else if (n < 8) begin
        read_check("rand_status", STATUS_ADDR);
      end else begin
        r = $urandom;
        read_check("rand_read", {($urandom_range(0, 1) == 0) ? 4'h3 : 4'hB, r[27:0]});
      end
      repeat ($urandom_range(0, 200)) step();
    end
    drain("final_drain");
    read_check("final_status", STATUS_ADDR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
